otp_stream_xor: RTL and testbench
=================================

Name: otp_stream_xor

Overview:
- Initiator-side consumer for the one-time-pad memory: drives its addr/wdata/we/rdata port.
- Accepts a stream of plaintext words and fetches the next unused pad word from a monotonically advancing pointer.
- Emits plaintext XOR pad, then overwrites the used pad word with zero so it is never reused.
- Sits between the host data path and the pad memory instance; owns the only pad read/erase path.

Parameters:
- WIDTH, 128, data and pad word width in bits; must equal the pad memory WIDTH.
- DEPTH, 256, number of pad words available; pointer range 0..DEPTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext word valid.
- in_ready  output  1  block can accept a plaintext word.
- in_data  input  WIDTH  plaintext word.
- out_valid  output  1  ciphertext word valid.
- out_ready  input  1  downstream accepts ciphertext.
- out_data  output  WIDTH  ciphertext word (plaintext XOR pad).
- pad_addr  output  32  pad memory address, zero-extended pointer.
- pad_wdata  output  WIDTH  pad memory write data.
- pad_we  output  1  pad memory write enable.
- pad_rdata  input  WIDTH  pad memory read data; combinational from pad_addr, same cycle.
- exhausted  output  1  all DEPTH pad words consumed; sticky.
- pad_err  output  1  zero-pad detected; sticky (optional feature only).

Behaviour:
- Reset (async assert, sync-to-clk deassert not required internally): state=IDLE, ptr=0, data_reg=0, out_data=0, out_valid=0, in_ready=0 during reset, exhausted=0, pad_err=0, pad_we=0, pad_wdata=0, pad_addr=0.
- pad_addr = {zeros, ptr} in every state. pad_wdata = 0 always. pad_we = 1 only in ERASE.
- IDLE:
  - in_ready = !exhausted.
  - When in_valid && in_ready: latch in_data into data_reg and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH (1 cycle): out_data_reg <= data_reg ^ pad_rdata. Go to ERASE.
- ERASE (1 cycle):
  - pad_we=1 at pad_addr=ptr, writing zero.
  - If ptr==DEPTH-1: set exhausted=1 and hold ptr. Otherwise ptr <= ptr+1.
  - Go to OUT.
- OUT:
  - out_valid=1; out_data stable until accepted.
  - When out_ready: clear out_valid and go to IDLE.
  - Backpressure may hold OUT indefinitely; in_ready stays 0 throughout.
- in_ready is 0 in FETCH, ERASE and OUT; at most one word is in flight.
- Latency: input accept to out_valid = 3 cycles. Best-case throughput: 1 word per 4 cycles with out_ready held 1.
- Exhaustion:
  - After the word using pad index DEPTH-1 is erased, exhausted=1 and in_ready stays 0 until reset.
  - That final word still completes through OUT normally.
  - The pointer never wraps.
- Simultaneous in_valid with exhausted=1: the word is not accepted and no pad access occurs.
- Reset mid-operation (FETCH, ERASE or OUT): the in-flight word is discarded and out_valid drops immediately. Pad memory shares rst_n and zeroizes itself, so a skipped erase leaks nothing.
- in_data is sampled only on the accept cycle; later changes are ignored.

Optional Feature:
- Macro: OTP_ZERO_CHECK_EN.
- Defined:
  - In FETCH, if pad_rdata == 0 (uninitialised or consumed), set pad_err=1 (sticky until reset).
  - Still ERASE and advance ptr, but skip OUT: no out_valid for that word, return to IDLE.
- Undefined:
  - A zero pad word is used as-is, so ciphertext equals plaintext.
  - pad_err is tied to 0.

Test Plan:
- Reset, preload pad[0]=0x...00FF, send in_data=0x...0F0F with out_ready=1 -> out_valid 3 cycles after accept, out_data=0x...0FF0, pad[0] reads 0 afterwards, pad_addr then shows 1.
- Back-to-back stream of 4 words, pad[0..3]=1,2,3,4, in_data=0x10 each -> outputs 0x11,0x12,0x13,0x10^0x4=0x14 in order; in_ready pulses once per 4 cycles.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid and out_data stable, in_ready=0, pad_we never reasserts, single erase per word.
- DEPTH=4 build, send 5 words -> 4 outputs, exhausted=1 after the 4th ERASE, 5th word never accepted (in_ready=0), pad_addr held at 3.
- Assert rst_n=0 during ERASE -> out_valid=0, ptr=0, exhausted=0 immediately; next word uses pad index 0.
- With OTP_ZERO_CHECK_EN, pad[0]=0, pad[1]=0xAA, send 2 words of 0x55:
  - Expect pad_err=1, a single output 0xFF from index 1, and ptr=2.
  - Without the macro: outputs 0x55 then 0xFF, and pad_err=0.

Source files
------------

// File: rtl/otp_stream_xor.sv
// One-time-pad stream encryptor: each plaintext word is XORed with the next unused pad word, then that pad word is erased.
// Build option OTP_ZERO_CHECK_EN: a pad word that reads back as zero raises sticky pad_err and its word is dropped.
module otp_stream_xor #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      pad_addr,
    output logic [WIDTH-1:0] pad_wdata,
    output logic             pad_we,
    input  logic [WIDTH-1:0] pad_rdata,
    output logic             exhausted,
    output logic             pad_err
);
    // state | meaning
    // IDLE  | waiting for a plaintext word; ready unless the pad is exhausted
    // FETCH | pad word visible on pad_rdata; ciphertext registered
    // ERASE | zero written to pad[ptr]; pointer advanced or exhausted set
    // OUT   | ciphertext held on out_data until out_ready

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ERASE = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic            exhausted_q;
    logic            pad_err_q;
    logic            drop_q;
    logic            can_accept;

    // in_ready is gated by rst_n so it reads low while reset is held
    assign can_accept = rst_n && !exhausted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        pad_we    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = can_accept;
                if (in_valid && can_accept) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_ERASE;
            end
            S_ERASE: begin
                pad_we    = 1'b1;
                state_nxt = drop_q ? S_IDLE : S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            data_reg     <= '0;
            out_data_reg <= '0;
            exhausted_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && can_accept) begin
                        data_reg <= in_data;
                    end
                end
                S_FETCH: begin
                    out_data_reg <= data_reg ^ pad_rdata;
                end
                S_ERASE: begin
                    // pointer never wraps: the last index is held once used
                    if (ptr == LAST_IDX) begin
                        exhausted_q <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef OTP_ZERO_CHECK_EN
    logic zero_pad;
    assign zero_pad = (pad_rdata == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_err_q <= 1'b0;
            drop_q    <= 1'b0;
        end else if (state == S_FETCH) begin
            drop_q <= zero_pad;
            if (zero_pad) begin
                pad_err_q <= 1'b1;
            end
        end
    end
`else
    assign pad_err_q = 1'b0;
    assign drop_q    = 1'b0;
`endif

    assign out_data  = out_data_reg;
    assign pad_addr  = 32'(ptr);
    assign pad_wdata = '0;
    assign exhausted = exhausted_q;
    assign pad_err   = pad_err_q;

endmodule

// File: tb/tb_otp_stream_xor.sv
// Bench for otp_stream_xor: pad memory model plus a reference model of pointer, pad contents and expected ciphertext.
module tb_otp_stream_xor;
    localparam int WIDTH = 128;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
`ifdef OTP_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [31:0]      pad_addr;
    logic [WIDTH-1:0] pad_wdata;
    logic             pad_we;
    logic [WIDTH-1:0] pad_rdata;
    logic             exhausted;
    logic             pad_err;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             pre_we = 1'b0;
    logic [AW-1:0]    pre_idx = '0;
    logic [WIDTH-1:0] pre_val = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int erase_cnt = 0;
    int acc_cyc = 0;

    logic [WIDTH-1:0] model_pad [DEPTH];
    int m_ptr = 0;
    bit m_exh = 1'b0;
    bit m_err = 1'b0;

    otp_stream_xor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .pad_addr(pad_addr), .pad_wdata(pad_wdata), .pad_we(pad_we), .pad_rdata(pad_rdata),
        .exhausted(exhausted), .pad_err(pad_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && pad_we) erase_cnt <= erase_cnt + 1;
    end

    // pad memory: zeroizes on reset, combinational read
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pad_we) begin
            mem[pad_addr[AW-1:0]] <= pad_wdata;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end
    end
    assign pad_rdata = mem[pad_addr[AW-1:0]];

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_now);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        if (check_now) begin
            chk("rst_in_ready", WIDTH'(in_ready), '0);
            chk("rst_out_valid", WIDTH'(out_valid), '0);
            chk("rst_out_data", out_data, '0);
            chk("rst_pad_we", WIDTH'(pad_we), '0);
            chk("rst_pad_addr", WIDTH'(pad_addr), '0);
            chk("rst_pad_wdata", pad_wdata, '0);
            chk("rst_exhausted", WIDTH'(exhausted), '0);
            chk("rst_pad_err", WIDTH'(pad_err), '0);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        m_ptr = 0;
        m_exh = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_pad[i] = '0;
    endtask

    task automatic preload(input int idx, input logic [WIDTH-1:0] val);
        pre_idx = AW'(idx);
        pre_val = val;
        pre_we = 1'b1;
        step();
        pre_we = 1'b0;
        model_pad[idx] = val;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int hold);
        int k;
        int lat;
        int e0;
        int idx;
        logic [WIDTH-1:0] padv;
        logic [WIDTH-1:0] exp;
        bit drop;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        if (!in_ready) begin
            chk("accept_timeout", WIDTH'(in_ready), WIDTH'(1));
            return;
        end
        in_valid = 1'b1;
        in_data = d;
        e0 = erase_cnt;
        idx = m_ptr;
        step();
        acc_cyc = cyc;
        in_valid = 1'b0;
        in_data = rand_word();
        padv = model_pad[idx];
        model_pad[idx] = '0;
        drop = ZC && (padv == '0);
        if (drop) m_err = 1'b1;
        exp = d ^ padv;
        if (m_ptr == DEPTH - 1) m_exh = 1'b1;
        else m_ptr++;
        chk("busy_in_ready", WIDTH'(in_ready), '0);
        lat = 1;
        while (!out_valid && lat < 8) begin
            if (pad_we) begin
                chk("erase_addr", WIDTH'(pad_addr), WIDTH'(idx));
                chk("erase_wdata", pad_wdata, '0);
            end
            step();
            lat++;
        end
        if (drop) begin
            chk("drop_no_out", WIDTH'(out_valid), '0);
        end else begin
            chk("latency", WIDTH'(lat), WIDTH'(3));
            chk("out_data", out_data, exp);
            for (int h = 0; h < hold; h++) begin
                chk("hold_valid", WIDTH'(out_valid), WIDTH'(1));
                chk("hold_data", out_data, exp);
                chk("hold_in_ready", WIDTH'(in_ready), '0);
                step();
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("out_release", WIDTH'(out_valid), '0);
        end
        chk("erase_once", WIDTH'(erase_cnt - e0), WIDTH'(1));
        chk("pad_erased", mem[idx], '0);
        chk("ptr", WIDTH'(pad_addr), WIDTH'(m_ptr));
        chk("exhausted", WIDTH'(exhausted), WIDTH'(m_exh));
        chk("pad_err", WIDTH'(pad_err), WIDTH'(m_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int e0;
        bit seen;
        logic [WIDTH-1:0] v;

        // basic word
        do_reset(1'b1);
        preload(0, WIDTH'(128'h00FF));
        send(WIDTH'(128'h0F0F), 0);

        // back-to-back stream, best-case throughput
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) preload(i, WIDTH'(i + 1));
        send(WIDTH'(128'h10), 0);
        prev = acc_cyc;
        for (int i = 1; i < 4; i++) begin
            send(WIDTH'(128'h10), 0);
            chk("throughput", WIDTH'(acc_cyc - prev), WIDTH'(4));
            prev = acc_cyc;
        end

        // backpressure held in OUT
        do_reset(1'b0);
        preload(0, rand_word() | WIDTH'(1));
        send(rand_word(), 10);

        // random stream to exhaustion
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) preload(i, rand_word() | WIDTH'(1));
        for (int i = 0; i < DEPTH; i++) send(rand_word(), int'($urandom_range(0, 3)));
        in_valid = 1'b1;
        in_data = rand_word();
        e0 = erase_cnt;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready || out_valid) seen = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("exh_blocked", WIDTH'(seen), '0);
        chk("exh_no_erase", WIDTH'(erase_cnt - e0), '0);
        chk("exh_addr_held", WIDTH'(pad_addr), WIDTH'(DEPTH - 1));
        chk("exh_sticky", WIDTH'(exhausted), WIDTH'(1));

        // reset while in ERASE
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) preload(i, rand_word() | WIDTH'(1));
        send(rand_word(), 1);
        send(rand_word(), 0);
        in_valid = 1'b1;
        in_data = rand_word();
        step();
        in_valid = 1'b0;
        step();
        chk("in_erase", WIDTH'(pad_we), WIDTH'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", WIDTH'(out_valid), '0);
        chk("mid_rst_ptr", WIDTH'(pad_addr), '0);
        chk("mid_rst_exhausted", WIDTH'(exhausted), '0);
        chk("mid_rst_pad_we", WIDTH'(pad_we), '0);
        do_reset(1'b0);
        v = rand_word() | WIDTH'(1);
        preload(0, v);
        send(rand_word(), 0);

        // zero pad word at index 0
        do_reset(1'b0);
        preload(0, '0);
        preload(1, WIDTH'(128'hAA));
        send(WIDTH'(128'h55), 0);
        send(WIDTH'(128'h55), 0);
        chk("zero_ptr", WIDTH'(pad_addr), WIDTH'(2));
        chk("zero_err", WIDTH'(pad_err), WIDTH'(ZC));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
